// File: rtl/alu_seq_pkg.sv
// Shared opcodes, ALU control words and FSM states for alu_sequencer.
// Control word bit order is {zx, nx, zy, ny, f, no}.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        ONE   = 4'd1,
        NEG1  = 4'd2,
        X     = 4'd3,
        Y     = 4'd4,
        NOTX  = 4'd5,
        NOTY  = 4'd6,
        NEGX  = 4'd7,
        NEGY  = 4'd8,
        XP1   = 4'd9,
        YP1   = 4'd10,
        XM1   = 4'd11,
        YM1   = 4'd12,
        XPY   = 4'd13,
        XMY   = 4'd14,
        XANDY = 4'd15
    } op_e;

    localparam logic [5:0] CTL_ZERO  = 6'b101010;
    localparam logic [5:0] CTL_ONE   = 6'b111111;
    localparam logic [5:0] CTL_NEG1  = 6'b111010;
    localparam logic [5:0] CTL_X     = 6'b001100;
    localparam logic [5:0] CTL_Y     = 6'b110000;
    localparam logic [5:0] CTL_NOTX  = 6'b001101;
    localparam logic [5:0] CTL_NOTY  = 6'b110001;
    localparam logic [5:0] CTL_NEGX  = 6'b001111;
    localparam logic [5:0] CTL_NEGY  = 6'b110011;
    localparam logic [5:0] CTL_XP1   = 6'b011111;
    localparam logic [5:0] CTL_YP1   = 6'b110111;
    localparam logic [5:0] CTL_XM1   = 6'b001110;
    localparam logic [5:0] CTL_YM1   = 6'b110010;
    localparam logic [5:0] CTL_XPY   = 6'b000010;
    localparam logic [5:0] CTL_XMY   = 6'b010011;
    localparam logic [5:0] CTL_XANDY = 6'b000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_ctl_decode.sv
// Opcode to ALU control word decoder, usable by any ALU master.
// Output bit order is {zx, nx, zy, ny, f, no}.
module alu_ctl_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0] op,
    output logic [5:0] ctl
);

    always_comb begin
        ctl = CTL_ZERO;
        unique case (op)
            ZERO:  ctl = CTL_ZERO;
            ONE:   ctl = CTL_ONE;
            NEG1:  ctl = CTL_NEG1;
            X:     ctl = CTL_X;
            Y:     ctl = CTL_Y;
            NOTX:  ctl = CTL_NOTX;
            NOTY:  ctl = CTL_NOTY;
            NEGX:  ctl = CTL_NEGX;
            NEGY:  ctl = CTL_NEGY;
            XP1:   ctl = CTL_XP1;
            YP1:   ctl = CTL_YP1;
            XM1:   ctl = CTL_XM1;
            YM1:   ctl = CTL_YM1;
            XPY:   ctl = CTL_XPY;
            XMY:   ctl = CTL_XMY;
            XANDY: ctl = CTL_XANDY;
            default: ctl = CTL_ZERO;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Command sequencer for the external combinational ALU with accumulator.
// Optional ALU_SEQ_REPEAT_EN adds cmd_rep: extra chained passes per command.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_op,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic         cmd_chain,
`ifdef ALU_SEQ_REPEAT_EN
    input  logic [1:0]   cmd_rep,
`endif
    output logic         alu_zx,
    output logic         alu_nx,
    output logic         alu_zy,
    output logic         alu_ny,
    output logic         alu_f,
    output logic         alu_no,
    output logic [W-1:0] alu_x,
    output logic [W-1:0] alu_y,
    input  logic [W-1:0] alu_o,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_zr,
    output logic         res_ng
);

    state_e       state_q;
    state_e       state_d;
    logic [3:0]   op_q;
    logic [W-1:0] x_q;
    logic [W-1:0] y_q;
    logic [W-1:0] acc_q;
    logic [5:0]   ctl;
    logic         accept;
    logic         in_exec;
    logic         last_pass;

    assign accept  = (state_q == IDLE) && cmd_valid;
    assign in_exec = (state_q == EXEC);

`ifdef ALU_SEQ_REPEAT_EN
    logic [1:0] rep_q;
    assign last_pass = (rep_q == 2'd0);
`else
    assign last_pass = 1'b1;
`endif

    alu_ctl_decode u_decode (
        .op  (op_q),
        .ctl (ctl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (cmd_valid) state_d = EXEC;
            EXEC: if (last_pass) state_d = RESP;
            RESP: if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // x_q follows the ALU result so later repeat passes reuse it as x.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= 4'd0;
            x_q   <= '0;
            y_q   <= '0;
            acc_q <= '0;
        end else if (accept) begin
            op_q <= cmd_op;
            x_q  <= cmd_chain ? acc_q : cmd_a;
            y_q  <= cmd_b;
        end else if (in_exec) begin
            acc_q <= alu_o;
            x_q   <= alu_o;
        end
    end

`ifdef ALU_SEQ_REPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_q <= 2'd0;
        end else if (accept) begin
            rep_q <= cmd_rep;
        end else if (in_exec && !last_pass) begin
            rep_q <= rep_q - 2'd1;
        end
    end
`endif

    always_comb begin
        cmd_ready = (state_q == IDLE);
        res_valid = (state_q == RESP);
        {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = '0;
        alu_x     = '0;
        alu_y     = '0;
        res_data  = '0;
        res_zr    = 1'b0;
        res_ng    = 1'b0;
        if (in_exec) begin
            {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ctl;
            alu_x = x_q;
            alu_y = y_q;
        end
        if (res_valid) begin
            res_data = acc_q;
            res_zr   = (acc_q == '0);
            res_ng   = acc_q[W-1];
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural 4-bit ALU.
// Build with ALU_SEQ_REPEAT_EN to also exercise the repeat feature.
module tb_alu_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_op;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         cmd_chain;
`ifdef ALU_SEQ_REPEAT_EN
    logic [1:0]   cmd_rep;
`endif
    logic         alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic [W-1:0] alu_x;
    logic [W-1:0] alu_y;
    logic [W-1:0] alu_o;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_zr;
    logic         res_ng;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] model_acc;
    logic [1:0] cur_rep;

    logic [5:0] ctl_tab [16] = '{
        6'b101010, 6'b111111, 6'b111010, 6'b001100,
        6'b110000, 6'b001101, 6'b110001, 6'b001111,
        6'b110011, 6'b011111, 6'b110111, 6'b001110,
        6'b110010, 6'b000010, 6'b010011, 6'b000000
    };

    always #5 clk = ~clk;

    alu_sequencer #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_chain (cmd_chain),
`ifdef ALU_SEQ_REPEAT_EN
        .cmd_rep   (cmd_rep),
`endif
        .alu_zx    (alu_zx),
        .alu_nx    (alu_nx),
        .alu_zy    (alu_zy),
        .alu_ny    (alu_ny),
        .alu_f     (alu_f),
        .alu_no    (alu_no),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_o     (alu_o),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zr    (res_zr),
        .res_ng    (res_ng)
    );

    // The team's combinational ALU
    logic [3:0] ax, ay, ao;
    always_comb begin
        ax = alu_zx ? 4'd0 : alu_x;
        if (alu_nx) ax = ~ax;
        ay = alu_zy ? 4'd0 : alu_y;
        if (alu_ny) ay = ~ay;
        ao = alu_f ? ax + ay : ax & ay;
        if (alu_no) ao = ~ao;
        alu_o = ao;
    end

    function automatic logic [3:0] ref_op(input logic [3:0] op, input logic [3:0] x, input logic [3:0] y);
        case (op)
            4'd0:  return 4'd0;
            4'd1:  return 4'd1;
            4'd2:  return 4'hF;
            4'd3:  return x;
            4'd4:  return y;
            4'd5:  return ~x;
            4'd6:  return ~y;
            4'd7:  return 4'd0 - x;
            4'd8:  return 4'd0 - y;
            4'd9:  return x + 4'd1;
            4'd10: return y + 4'd1;
            4'd11: return x - 4'd1;
            4'd12: return y - 4'd1;
            4'd13: return x + y;
            4'd14: return x - y;
            default: return x & y;
        endcase
    endfunction

    function automatic logic [19:0] alu_bus();
        return {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_x, alu_y, 2'b00};
    endfunction

    // Drives one command and returns what the DUT showed; lat = -1 on timeout.
    task automatic run_op(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic chain, input int hold,
                          output logic [3:0] d, output logic zr, output logic ng,
                          output int lat, output logic [5:0] ctl_ex,
                          output logic [3:0] x_ex, output logic [3:0] y_ex,
                          output logic [19:0] resp_bus);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_chain = chain;
`ifdef ALU_SEQ_REPEAT_EN
        cmd_rep   = cur_rep;
`endif
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_a     = 4'($urandom);
        cmd_b     = 4'($urandom);
        ctl_ex    = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
        x_ex      = alu_x;
        y_ex      = alu_y;
        lat = 1;
        while (!res_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!res_valid) lat = -1;
        d        = res_data;
        zr       = res_zr;
        ng       = res_ng;
        resp_bus = alu_bus();
        repeat (hold) @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({cmd_ready, res_valid, res_data, res_zr, res_ng} !== 8'b1000_0000) begin
            n_bad++;
            $display("FAIL reset_outs: got %b want 10000000",
                     {cmd_ready, res_valid, res_data, res_zr, res_ng});
        end
        n_cmp++;
        if (alu_bus() !== 20'd0) begin
            n_bad++;
            $display("FAIL reset_alu_bus: got %h want 0", alu_bus());
        end
        rst = 1'b0;
        model_acc = 4'd0;
    endtask

    task automatic test_xpy();
        logic [3:0] d, xe, ye;
        logic zr, ng;
        logic [5:0] c;
        logic [19:0] rb;
        int lat;
        run_op(4'd13, 4'd8, 4'd7, 1'b0, 0, d, zr, ng, lat, c, xe, ye, rb);
        n_cmp++;
        if (d !== 4'd15) begin n_bad++; $display("FAIL xpy_data: got %0d want 15", d); end
        n_cmp++;
        if ({zr, ng} !== 2'b01) begin n_bad++; $display("FAIL xpy_flags: got zr,ng=%b want 01", {zr, ng}); end
        n_cmp++;
        if (lat !== 2) begin n_bad++; $display("FAIL xpy_latency: got %0d want 2", lat); end
        n_cmp++;
        if ({c, xe, ye} !== {6'b000010, 4'd8, 4'd7}) begin
            n_bad++;
            $display("FAIL xpy_exec_bus: got %b/%0d/%0d want 000010/8/7", c, xe, ye);
        end
        model_acc = 4'd15;
    endtask

    task automatic test_xmy_chain();
        logic [3:0] d, xe, ye;
        logic zr, ng;
        logic [5:0] c;
        logic [19:0] rb;
        int lat;
        run_op(4'd14, 4'd3, 4'd5, 1'b0, 1, d, zr, ng, lat, c, xe, ye, rb);
        n_cmp++;
        if ({d, ng} !== {4'd14, 1'b1}) begin
            n_bad++;
            $display("FAIL xmy_result: got %0d ng=%b want 14 ng=1", d, ng);
        end
        run_op(4'd9, 4'($urandom), 4'($urandom), 1'b1, 0, d, zr, ng, lat, c, xe, ye, rb);
        n_cmp++;
        if (d !== 4'd15) begin n_bad++; $display("FAIL chain_xp1: got %0d want 15", d); end
        model_acc = 4'd15;
    endtask

    task automatic test_chain_zero();
        logic [3:0] d, xe, ye;
        logic zr, ng;
        logic [5:0] c;
        logic [19:0] rb;
        int lat;
        run_op(4'd9, 4'd2, 4'd2, 1'b1, 0, d, zr, ng, lat, c, xe, ye, rb);
        n_cmp++;
        if ({d, zr, ng} !== {4'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL chain_wrap: got %0d zr=%b ng=%b want 0 zr=1 ng=0", d, zr, ng);
        end
        run_op(4'd0, 4'd9, 4'd6, 1'b0, 0, d, zr, ng, lat, c, xe, ye, rb);
        n_cmp++;
        if ({d, zr} !== {4'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL op_zero: got %0d zr=%b want 0 zr=1", d, zr);
        end
        model_acc = 4'd0;
    endtask

    task automatic test_backpressure();
        logic [3:0] d0, d, xe, ye;
        logic zr0, ng0, zr, ng;
        logic [5:0] c;
        logic [19:0] rb;
        int lat;
        int waits;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 4'd8; cmd_a = 4'd1; cmd_b = 4'd6; cmd_chain = 1'b0;
`ifdef ALU_SEQ_REPEAT_EN
        cmd_rep = 2'd0;
`endif
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        waits = 0;
        while (!res_valid && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        n_cmp++;
        if (res_valid !== 1'b1) begin n_bad++; $display("FAIL bp_timeout: got res_valid=%b want 1", res_valid); end
        d0 = res_data; zr0 = res_zr; ng0 = res_ng;
        n_cmp++;
        if ({d0, zr0, ng0} !== {4'd10, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL bp_negy: got %0d zr=%b ng=%b want 10 zr=0 ng=1", d0, zr0, ng0);
        end
        for (int i = 0; i < 3; i++) begin
            cmd_valid = (i == 1);
            cmd_op = 4'd1;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            n_cmp++;
            if ({res_valid, res_data, res_zr, res_ng, cmd_ready} !== {1'b1, d0, zr0, ng0, 1'b0}) begin
                n_bad++;
                $display("FAIL bp_hold%0d: got v=%b d=%0d zr=%b ng=%b rdy=%b want v=1 d=%0d rdy=0",
                         i, res_valid, res_data, res_zr, res_ng, cmd_ready, d0);
            end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        n_cmp++;
        if ({cmd_ready, res_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL bp_release: got rdy=%b v=%b want rdy=1 v=0", cmd_ready, res_valid);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({cmd_ready, res_valid, alu_bus()} !== {2'b10, 20'd0}) begin
            n_bad++;
            $display("FAIL bp_pulse_dropped: got rdy=%b v=%b bus=%h want idle", cmd_ready, res_valid, alu_bus());
        end
        run_op(4'd3, 4'd5, 4'd5, 1'b1, 0, d, zr, ng, lat, c, xe, ye, rb);
        n_cmp++;
        if (d !== 4'd10) begin n_bad++; $display("FAIL bp_acc_kept: got %0d want 10", d); end
        model_acc = 4'd10;
    endtask

    task automatic test_reset_exec();
        logic [3:0] d, xe, ye;
        logic zr, ng;
        logic [5:0] c;
        logic [19:0] rb;
        int lat;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 4'd13; cmd_a = 4'd4; cmd_b = 4'd3; cmd_chain = 1'b0;
`ifdef ALU_SEQ_REPEAT_EN
        cmd_rep = 2'd3;
`endif
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if ({cmd_ready, res_valid, res_data, res_zr, res_ng, alu_bus()} !== {8'b1000_0000, 20'd0}) begin
            n_bad++;
            $display("FAIL rst_exec: got rdy=%b v=%b d=%0d bus=%h want reset values",
                     cmd_ready, res_valid, res_data, alu_bus());
        end
        model_acc = 4'd0;
        run_op(4'd3, 4'd11, 4'd12, 1'b1, 0, d, zr, ng, lat, c, xe, ye, rb);
        n_cmp++;
        if ({d, zr} !== {4'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL rst_chain_x: got %0d zr=%b want 0 zr=1", d, zr);
        end
    endtask

    task automatic test_repeat();
`ifdef ALU_SEQ_REPEAT_EN
        logic [3:0] d, xe, ye;
        logic zr, ng;
        logic [5:0] c;
        logic [19:0] rb;
        int lat;
        cur_rep = 2'd2;
        run_op(4'd9, 4'd5, 4'($urandom), 1'b0, 0, d, zr, ng, lat, c, xe, ye, rb);
        cur_rep = 2'd0;
        n_cmp++;
        if (d !== 4'd8) begin n_bad++; $display("FAIL rep_data: got %0d want 8", d); end
        n_cmp++;
        if (lat !== 4) begin n_bad++; $display("FAIL rep_latency: got %0d want 4", lat); end
        model_acc = 4'd8;
`endif
    endtask

    task automatic test_random();
        logic [3:0] op, a, b, x, r, d, xe, ye;
        logic chain, zr, ng;
        logic [5:0] c;
        logic [19:0] rb;
        int lat;
        for (int i = 0; i < 40; i++) begin
            op    = 4'($urandom);
            a     = 4'($urandom);
            b     = 4'($urandom);
            chain = 1'($urandom);
`ifdef ALU_SEQ_REPEAT_EN
            cur_rep = 2'($urandom);
`endif
            x = chain ? model_acc : a;
            r = x;
            for (int p = 0; p <= int'(cur_rep); p++) r = ref_op(op, r, b);
            run_op(op, a, b, chain, $urandom_range(0, 2), d, zr, ng, lat, c, xe, ye, rb);
            n_cmp++;
            if ({d, zr, ng} !== {r, r == 4'd0, r[3]}) begin
                n_bad++;
                $display("FAIL rnd%0d_result: op=%0d x=%0d y=%0d got %0d zr=%b ng=%b want %0d",
                         i, op, x, b, d, zr, ng, r);
            end
            n_cmp++;
            if ({c, xe, ye} !== {ctl_tab[op], x, b}) begin
                n_bad++;
                $display("FAIL rnd%0d_exec_bus: got %b/%0d/%0d want %b/%0d/%0d",
                         i, c, xe, ye, ctl_tab[op], x, b);
            end
            n_cmp++;
            if (lat !== 2 + int'(cur_rep) || rb !== 20'd0) begin
                n_bad++;
                $display("FAIL rnd%0d_timing: got lat=%0d resp_bus=%h want lat=%0d bus=0",
                         i, lat, rb, 2 + int'(cur_rep));
            end
            model_acc = r;
        end
        cur_rep = 2'd0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 4'd0;
        cmd_a     = 4'd0;
        cmd_b     = 4'd0;
        cmd_chain = 1'b0;
`ifdef ALU_SEQ_REPEAT_EN
        cmd_rep   = 2'd0;
`endif
        res_ready = 1'b0;
        cur_rep   = 2'd0;
        model_acc = 4'd0;
        test_reset();
        test_xpy();
        test_xmy_chain();
        test_chain_zero();
        test_backpressure();
        test_reset_exec();
        test_repeat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
